// File: rtl/xgmii_rx_link_ctrl.sv
// XGMII RX link controller: link-fault sequence FSM, start-lane tracking
// and TX mode control. Two XGMII columns are stepped per clock, column 0
// first, and every output is registered.
module xgmii_rx_link_ctrl #(
  parameter int unsigned COL_WINDOW  = 128,
  parameter int unsigned SEQ_THRESH  = 4,
  parameter int unsigned LOCK_FRAMES = 4
) (
  input  logic        xgmii_rx_clk,
  input  logic        sys_rst_n,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  output logic [1:0]  link_status,
  output logic [1:0]  tx_mode,
  output logic [1:0]  start_lane,
  output logic        align_locked,
  output logic [15:0] fault_cnt
);

  localparam int unsigned COL_W       = 32;
  localparam int unsigned COL_CTRL_W  = 4;
  localparam int unsigned COL_CNT_W   = 8;
  localparam int unsigned SEQ_CNT_W   = 4;
  localparam int unsigned LOCK_CNT_W  = 4;
  localparam int unsigned FAULT_CNT_W = 16;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  // Sequence types share the link_status encoding
  localparam logic [1:0] SEQ_NONE = 2'b00;
  localparam logic [1:0] SEQ_LF   = 2'b01;
  localparam logic [1:0] SEQ_RF   = 2'b10;

  localparam logic [1:0] TX_DATA = 2'b00;
  localparam logic [1:0] TX_IDLE = 2'b01;
  localparam logic [1:0] TX_RFLT = 2'b10;

  localparam logic [7:0] CH_SEQ   = 8'h9C;
  localparam logic [7:0] CH_START = 8'hFB;

  // Last OTHER column that still only increments; the next one leaves
  localparam logic [COL_CNT_W-1:0]   COL_LAST  = COL_CNT_W'(COL_WINDOW - 1);
  localparam logic [SEQ_CNT_W-1:0]   SEQ_LAST  = SEQ_CNT_W'(SEQ_THRESH);
  localparam logic [LOCK_CNT_W-1:0]  LOCK_MAX  = LOCK_CNT_W'(LOCK_FRAMES);
  localparam logic [FAULT_CNT_W-1:0] FAULT_MAX = {FAULT_CNT_W{1'b1}};

  typedef struct packed {
    logic [1:0]             state;
    logic [1:0]             seq_type;
    logic [SEQ_CNT_W-1:0]   seq_cnt;
    logic [COL_CNT_W-1:0]   col_cnt;
    logic [1:0]             link;
    logic [FAULT_CNT_W-1:0] faults;
    logic                   fault_entry;
  } fault_ctx_t;

  logic [1:0]             state_q;
  logic [1:0]             seq_type_q;
  logic [SEQ_CNT_W-1:0]   seq_cnt_q;
  logic [COL_CNT_W-1:0]   col_cnt_q;
  logic [LOCK_CNT_W-1:0]  lock_cnt_q;

  fault_ctx_t             ctx_cur;
  fault_ctx_t             ctx_mid;
  fault_ctx_t             ctx_nxt;
  logic [1:0]             kind0;
  logic [1:0]             kind1;
  logic                   start_hit;
  logic [1:0]             start_new;
  logic [1:0]             start_lane_d;
  logic [LOCK_CNT_W-1:0]  lock_cnt_d;
  logic                   align_d;
  logic [1:0]             tx_mode_d;

  // Decode one column into LF, RF or OTHER
  function automatic logic [1:0] classify(input logic [COL_W-1:0] d,
                                          input logic [COL_CTRL_W-1:0] c);
    logic [1:0] kind;
    kind = SEQ_NONE;
    if (c == 4'b0001 && d[7:0] == CH_SEQ && d[15:8] == 8'h00 && d[23:16] == 8'h00) begin
      if (d[31:24] == 8'h01)
        kind = SEQ_LF;
      else if (d[31:24] == 8'h02)
        kind = SEQ_RF;
    end
    return kind;
  endfunction

  // One column step of the link-fault sequence machine
  function automatic fault_ctx_t col_step(input fault_ctx_t cur, input logic [1:0] kind);
    fault_ctx_t nxt;
    nxt = cur;
    case (cur.state)
      ST_INIT: begin
        if (kind != SEQ_NONE) begin
          nxt.seq_type = kind;
          nxt.seq_cnt  = SEQ_CNT_W'(1);
          nxt.col_cnt  = '0;
          nxt.state    = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (kind == SEQ_NONE) begin
          if (cur.col_cnt >= COL_LAST) begin
            nxt.state   = ST_INIT;
            nxt.seq_cnt = '0;
            nxt.col_cnt = '0;
          end else begin
            nxt.col_cnt = cur.col_cnt + COL_CNT_W'(1);
          end
        end else if (kind == cur.seq_type) begin
          nxt.seq_cnt = cur.seq_cnt + SEQ_CNT_W'(1);
          nxt.col_cnt = '0;
          if (nxt.seq_cnt >= SEQ_LAST) begin
            nxt.state       = ST_FAULT;
            nxt.link        = cur.seq_type;
            nxt.fault_entry = 1'b1;
            if (cur.faults != FAULT_MAX)
              nxt.faults = cur.faults + FAULT_CNT_W'(1);
          end
        end else begin
          nxt.seq_type = kind;
          nxt.seq_cnt  = SEQ_CNT_W'(1);
          nxt.col_cnt  = '0;
        end
      end
      ST_FAULT: begin
        if (kind != SEQ_NONE) begin
          nxt.col_cnt  = '0;
          nxt.seq_type = kind;
          nxt.link     = kind;
        end else if (cur.col_cnt >= COL_LAST) begin
          nxt.state   = ST_INIT;
          nxt.link    = SEQ_NONE;
          nxt.seq_cnt = '0;
          nxt.col_cnt = '0;
        end else begin
          nxt.col_cnt = cur.col_cnt + COL_CNT_W'(1);
        end
      end
      default: begin
        nxt.state   = ST_INIT;
        nxt.seq_cnt = '0;
        nxt.col_cnt = '0;
        nxt.link    = SEQ_NONE;
      end
    endcase
    return nxt;
  endfunction

  // Fault FSM next state: column 0 then column 1 in the same cycle
  always_comb begin
    ctx_cur             = '0;
    ctx_cur.state       = state_q;
    ctx_cur.seq_type    = seq_type_q;
    ctx_cur.seq_cnt     = seq_cnt_q;
    ctx_cur.col_cnt     = col_cnt_q;
    ctx_cur.link        = link_status;
    ctx_cur.faults      = fault_cnt;
    ctx_cur.fault_entry = 1'b0;
    kind0   = classify(xgmii_rxd[31:0],  xgmii_rxc[3:0]);
    kind1   = classify(xgmii_rxd[63:32], xgmii_rxc[7:4]);
    ctx_mid = col_step(ctx_cur, kind0);
    ctx_nxt = col_step(ctx_mid, kind1);
    case (ctx_nxt.link)
      SEQ_LF:  tx_mode_d = TX_RFLT;
      SEQ_RF:  tx_mode_d = TX_IDLE;
      default: tx_mode_d = TX_DATA;
    endcase
  end

  // Start detection (lowest even lane wins) and lock tracking
  always_comb begin
    start_hit    = 1'b0;
    start_new    = 2'd0;
    start_lane_d = start_lane;
    lock_cnt_d   = lock_cnt_q;
    align_d      = align_locked;
    for (int i = 3; i >= 0; i--) begin
      if (xgmii_rxc[2*i] && xgmii_rxd[16*i +: 8] == CH_START) begin
        start_hit = 1'b1;
        start_new = 2'(i);
      end
    end
    if (start_hit && state_q != ST_FAULT) begin
      if (start_new == start_lane) begin
        if (lock_cnt_q < LOCK_MAX)
          lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
        align_d = (lock_cnt_d >= LOCK_MAX);
      end else begin
        start_lane_d = start_new;
        lock_cnt_d   = LOCK_CNT_W'(1);
        align_d      = 1'b0;
      end
    end
    if (ctx_nxt.fault_entry) begin
      lock_cnt_d = '0;
      align_d    = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge xgmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_INIT;
      seq_type_q   <= SEQ_NONE;
      seq_cnt_q    <= '0;
      col_cnt_q    <= '0;
      lock_cnt_q   <= '0;
      link_status  <= SEQ_NONE;
      tx_mode      <= TX_DATA;
      start_lane   <= 2'd0;
      align_locked <= 1'b0;
      fault_cnt    <= '0;
    end else begin
      state_q      <= ctx_nxt.state;
      seq_type_q   <= ctx_nxt.seq_type;
      seq_cnt_q    <= ctx_nxt.seq_cnt;
      col_cnt_q    <= ctx_nxt.col_cnt;
      lock_cnt_q   <= lock_cnt_d;
      link_status  <= ctx_nxt.link;
      tx_mode      <= tx_mode_d;
      start_lane   <= start_lane_d;
      align_locked <= align_d;
      fault_cnt    <= ctx_nxt.faults;
    end
  end

endmodule

// File: tb/tb_xgmii_rx_link_ctrl.sv
// Directed bench for xgmii_rx_link_ctrl with hand-computed expectations.
module tb_xgmii_rx_link_ctrl;

  logic        xgmii_rx_clk;
  logic        sys_rst_n;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic [1:0]  link_status;
  logic [1:0]  tx_mode;
  logic [1:0]  start_lane;
  logic        align_locked;
  logic [15:0] fault_cnt;

  int checks;
  int errors;

  localparam logic [63:0] D_IDLE  = 64'h0707070707070707;
  localparam logic [63:0] D_LF    = 64'h0100009C_0100009C;
  localparam logic [63:0] D_RF    = 64'h0200009C_0200009C;
  localparam logic [63:0] D_ALT   = 64'h0200009C_0100009C;
  localparam logic [63:0] D_BAD   = 64'h0300009C_0300009C;
  localparam logic [63:0] D_S4    = 64'h555555FB_55555555;
  localparam logic [63:0] D_S0    = 64'h55555555_555555FB;
  localparam logic [63:0] D_S26   = 64'h55FB5555_55FB5555;
  localparam logic [63:0] D_S0LF  = 64'h0100009C_555555FB;
  localparam logic [63:0] D_LFIDL = 64'h07070707_0100009C;

  xgmii_rx_link_ctrl dut (
    .xgmii_rx_clk (xgmii_rx_clk),
    .sys_rst_n    (sys_rst_n),
    .xgmii_rxd    (xgmii_rxd),
    .xgmii_rxc    (xgmii_rxc),
    .link_status  (link_status),
    .tx_mode      (tx_mode),
    .start_lane   (start_lane),
    .align_locked (align_locked),
    .fault_cnt    (fault_cnt)
  );

  initial xgmii_rx_clk = 1'b0;
  always #5 xgmii_rx_clk = ~xgmii_rx_clk;

  // Present one word for one clock; returns 1 time unit after the capturing edge
  task automatic send(input logic [63:0] d, input logic [7:0] c);
    xgmii_rxd = d;
    xgmii_rxc = c;
    @(posedge xgmii_rx_clk);
    #1;
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    xgmii_rxd = D_IDLE;
    xgmii_rxc = 8'hFF;
    #23;
    checks++;
    if ({link_status, tx_mode, start_lane, align_locked, fault_cnt} !== 23'd0) begin
      errors++;
      $display("FAIL reset_values: got ls=%b tx=%b sl=%0d al=%b fc=%0d, want all 0",
               link_status, tx_mode, start_lane, align_locked, fault_cnt);
    end
    sys_rst_n = 1'b1;
    #3;
    for (int i = 0; i < 300; i++) send(D_IDLE, 8'hFF);
    checks++;
    if ({link_status, tx_mode, align_locked, fault_cnt} !== 21'd0) begin
      errors++;
      $display("FAIL idle_300: got ls=%b tx=%b al=%b fc=%0d, want 00 00 0 0",
               link_status, tx_mode, align_locked, fault_cnt);
    end
  endtask

  task automatic test_lf_fault;
    send(D_LF, 8'h11);
    checks++;
    if (link_status !== 2'b00) begin
      errors++;
      $display("FAIL lf_two_cols: got ls=%b, want 00", link_status);
    end
    send(D_LF, 8'h11);
    checks++;
    if ({link_status, tx_mode, fault_cnt} !== {2'b01, 2'b10, 16'd1}) begin
      errors++;
      $display("FAIL lf_fault: got ls=%b tx=%b fc=%0d, want 01 10 1",
               link_status, tx_mode, fault_cnt);
    end
    for (int i = 0; i < 63; i++) send(D_IDLE, 8'hFF);
    checks++;
    if ({link_status, tx_mode} !== 4'b0110) begin
      errors++;
      $display("FAIL lf_hold_126: got ls=%b tx=%b, want 01 10", link_status, tx_mode);
    end
    send(D_IDLE, 8'hFF);
    checks++;
    if ({link_status, tx_mode, fault_cnt} !== {2'b00, 2'b00, 16'd1}) begin
      errors++;
      $display("FAIL lf_window_exit: got ls=%b tx=%b fc=%0d, want 00 00 1",
               link_status, tx_mode, fault_cnt);
    end
  endtask

  task automatic test_alternating;
    int bad;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      send(D_ALT, 8'h11);
      if (link_status !== 2'b00) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL alt_no_fault: %0d words with ls!=00, want 0", bad);
    end
    send(D_RF, 8'h11);
    checks++;
    if (link_status !== 2'b00) begin
      errors++;
      $display("FAIL rf_partial: got ls=%b, want 00", link_status);
    end
    send(D_RF, 8'h11);
    checks++;
    if ({link_status, tx_mode, fault_cnt} !== {2'b10, 2'b01, 16'd2}) begin
      errors++;
      $display("FAIL rf_fault: got ls=%b tx=%b fc=%0d, want 10 01 2",
               link_status, tx_mode, fault_cnt);
    end
  endtask

  task automatic test_fault_switch;
    send(D_LF, 8'h11);
    checks++;
    if ({link_status, tx_mode, fault_cnt} !== {2'b01, 2'b10, 16'd2}) begin
      errors++;
      $display("FAIL switch_to_lf: got ls=%b tx=%b fc=%0d, want 01 10 2",
               link_status, tx_mode, fault_cnt);
    end
    send(D_RF, 8'h11);
    checks++;
    if ({link_status, tx_mode, fault_cnt} !== {2'b10, 2'b01, 16'd2}) begin
      errors++;
      $display("FAIL switch_to_rf: got ls=%b tx=%b fc=%0d, want 10 01 2",
               link_status, tx_mode, fault_cnt);
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({link_status, tx_mode, start_lane, align_locked, fault_cnt} !== 23'd0) begin
      errors++;
      $display("FAIL async_reset: got ls=%b tx=%b sl=%0d al=%b fc=%0d, want all 0",
               link_status, tx_mode, start_lane, align_locked, fault_cnt);
    end
    #2;
    sys_rst_n = 1'b1;
    send(D_IDLE, 8'hFF);
    checks++;
    if ({link_status, tx_mode, fault_cnt} !== 20'd0) begin
      errors++;
      $display("FAIL post_reset_idle: got ls=%b tx=%b fc=%0d, want 00 00 0",
               link_status, tx_mode, fault_cnt);
    end
  endtask

  task automatic test_start_lock;
    for (int f = 1; f <= 4; f++) begin
      send(D_S4, 8'h10);
      send(D_IDLE, 8'hFF);
      checks++;
      if ({start_lane, align_locked} !== {2'd2, (f == 4)}) begin
        errors++;
        $display("FAIL lock_lane4_f%0d: got sl=%0d al=%b, want 2 %0d",
                 f, start_lane, align_locked, (f == 4));
      end
    end
    send(D_S0, 8'h01);
    checks++;
    if ({start_lane, align_locked, link_status} !== {2'd0, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL lane_change: got sl=%0d al=%b ls=%b, want 0 0 00",
               start_lane, align_locked, link_status);
    end
  endtask

  task automatic test_multi_start;
    send(D_S26, 8'h44);
    checks++;
    if ({start_lane, align_locked} !== {2'd1, 1'b0}) begin
      errors++;
      $display("FAIL lowest_lane: got sl=%0d al=%b, want 1 0", start_lane, align_locked);
    end
    send(D_BAD, 8'h11);
    send(D_BAD, 8'h11);
    checks++;
    if (link_status !== 2'b00) begin
      errors++;
      $display("FAIL bad_payload: got ls=%b, want 00", link_status);
    end
  endtask

  task automatic test_back_to_back;
    send(D_S0LF, 8'h11);
    checks++;
    if ({start_lane, align_locked, link_status} !== {2'd0, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL start_and_seq: got sl=%0d al=%b ls=%b, want 0 0 00",
               start_lane, align_locked, link_status);
    end
    for (int f = 2; f <= 4; f++) begin
      send(D_S0, 8'h01);
      checks++;
      if (align_locked !== (f == 4)) begin
        errors++;
        $display("FAIL lock_lane0_f%0d: got al=%b, want %0d", f, align_locked, (f == 4));
      end
    end
    send(D_LF, 8'h11);
    checks++;
    if (link_status !== 2'b00) begin
      errors++;
      $display("FAIL seq_cnt_3: got ls=%b, want 00", link_status);
    end
    send(D_LFIDL, 8'hF1);
    checks++;
    if ({link_status, tx_mode, fault_cnt, start_lane, align_locked} !==
        {2'b01, 2'b10, 16'd1, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL fault_clears_lock: got ls=%b tx=%b fc=%0d sl=%0d al=%b, want 01 10 1 0 0",
               link_status, tx_mode, fault_cnt, start_lane, align_locked);
    end
    send(D_S4, 8'h10);
    checks++;
    if ({start_lane, align_locked} !== {2'd0, 1'b0}) begin
      errors++;
      $display("FAIL start_in_fault: got sl=%0d al=%b, want 0 0", start_lane, align_locked);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lf_fault();
    test_alternating();
    test_fault_switch();
    test_start_lock();
    test_multi_start();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
